// File: rtl/neuro_pkg.sv
// Shared constants and types for the neuromorphic vector unit LIF stage.
// Optional build macro used by consumers of this package: LIF_SATURATE_EN.
package neuro_pkg;

    localparam int unsigned N_LANES    = 16;
    localparam int unsigned LANE_W     = 32;
    localparam int unsigned REFR_W     = 8;
    localparam int unsigned LEAK_SHIFT = 4;

    localparam int unsigned IDX_W      = $clog2(N_LANES);
    localparam int unsigned VEC_W      = N_LANES * LANE_W;
    localparam int unsigned VEC_IDX_W  = $clog2(VEC_W);
    // Lane i of a packed vector starts at bit (i << LANE_SHIFT).
    localparam int unsigned LANE_SHIFT = $clog2(LANE_W);

    typedef enum logic [1:0] {
        StIdle,
        StUpdate,
        StDone
    } lif_state_t;

endpackage

// File: rtl/lif_lane.sv
// Combinational single-neuron leaky integrate-and-fire update.
// Build macro LIF_SATURATE_EN: clamp non-firing potential instead of wrapping.
module lif_lane
    import neuro_pkg::*;
(
    input  logic signed [LANE_W-1:0] v,
    input  logic signed [LANE_W-1:0] cur,
    input  logic signed [LANE_W-1:0] vth,
    input  logic        [REFR_W-1:0] rc,
    input  logic        [REFR_W-1:0] rp,
    output logic signed [LANE_W-1:0] v_next,
    output logic                     spike,
    output logic        [REFR_W-1:0] rc_next
);

    logic signed [LANE_W-1:0] leak;
    logic signed [LANE_W:0]   v_ext;
    logic signed [LANE_W:0]   leak_ext;
    logic signed [LANE_W:0]   cur_ext;
    logic signed [LANE_W:0]   vth_ext;
    logic signed [LANE_W:0]   vn;
    logic signed [LANE_W-1:0] vn_fit;
    logic                     fire;

    assign leak     = v >>> LEAK_SHIFT;
    assign v_ext    = {v[LANE_W-1], v};
    assign leak_ext = {leak[LANE_W-1], leak};
    assign cur_ext  = {cur[LANE_W-1], cur};
    assign vth_ext  = {vth[LANE_W-1], vth};

    // One guard bit is enough: |V - leak| < 2^31 and |I| <= 2^31.
    assign vn   = v_ext - leak_ext + cur_ext;
    assign fire = (vn >= vth_ext);

`ifdef LIF_SATURATE_EN
    always_comb begin
        vn_fit = vn[LANE_W-1:0];
        if (vn[LANE_W] != vn[LANE_W-1]) begin
            vn_fit = vn[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        end
    end
`else
    assign vn_fit = vn[LANE_W-1:0];
`endif

    always_comb begin
        v_next  = v;
        spike   = 1'b0;
        rc_next = rc;
        if (rc != '0) begin
            rc_next = rc - REFR_W'(1);
        end else if (fire) begin
            v_next  = '0;
            spike   = 1'b1;
            rc_next = rp;
        end else begin
            v_next  = vn_fit;
        end
    end

endmodule

// File: rtl/lif_update.sv
// LIF update stage: captures a 16-lane batch and steps one neuron per cycle.
// Build macro LIF_SATURATE_EN (in lif_lane) selects saturating potential update.
module lif_update
    import neuro_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VEC_W-1:0]     cur_in,
    input  logic [VEC_W-1:0]     v_in,
    input  logic [LANE_W-1:0]    vth,
    input  logic [LANE_W-1:0]    rp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [VEC_W-1:0]     v_out,
    output logic [N_LANES-1:0]   spike_out,
    output logic                 busy
);

    lif_state_t           state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [VEC_W-1:0]     cur_q;
    logic [VEC_W-1:0]     v_cap_q;
    logic [LANE_W-1:0]    vth_q;
    logic [REFR_W-1:0]    rp_q;
    logic [REFR_W-1:0]    rc_q [N_LANES];

    logic [VEC_IDX_W-1:0] base;
    logic [LANE_W-1:0]    lane_v_next;
    logic                 lane_spike;
    logic [REFR_W-1:0]    lane_rc_next;

    // Only the low REFR_W bits of the period register are meaningful.
    logic unused_rp;
    assign unused_rp = ^rp[LANE_W-1:REFR_W];

    assign base = {idx_q, {LANE_SHIFT{1'b0}}};

    lif_lane u_lane (
        .v       (v_cap_q[base +: LANE_W]),
        .cur     (cur_q[base +: LANE_W]),
        .vth     (vth_q),
        .rc      (rc_q[idx_q]),
        .rp      (rp_q),
        .v_next  (lane_v_next),
        .spike   (lane_spike),
        .rc_next (lane_rc_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cur_q     <= '0;
            v_cap_q   <= '0;
            vth_q     <= '0;
            rp_q      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            v_out     <= '0;
            spike_out <= '0;
            for (int i = 0; i < int'(N_LANES); i++) begin
                rc_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        cur_q     <= cur_in;
                        v_cap_q   <= v_in;
                        vth_q     <= vth;
                        rp_q      <= rp[REFR_W-1:0];
                        spike_out <= '0;
                        idx_q     <= '0;
                        state_q   <= StUpdate;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                StUpdate: begin
                    v_out[base +: LANE_W] <= lane_v_next;
                    spike_out[idx_q]      <= lane_spike;
                    rc_q[idx_q]           <= lane_rc_next;
                    // Index wraps back to zero after the last lane.
                    idx_q                 <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N_LANES - 1)) begin
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_update.sv
// Directed self-checking bench for lif_update; expectations follow LIF_SATURATE_EN if defined.
module tb_lif_update;
    import neuro_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [VEC_W-1:0]    cur_in = '0;
    logic [VEC_W-1:0]    v_in = '0;
    logic [LANE_W-1:0]   vth = '0;
    logic [LANE_W-1:0]   rp = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [VEC_W-1:0]    v_out;
    logic [N_LANES-1:0]  spike_out;
    logic                busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    lif_update dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cur_in    (cur_in),
        .v_in      (v_in),
        .vth       (vth),
        .rp        (rp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .v_out     (v_out),
        .spike_out (spike_out),
        .busy      (busy)
    );

    function automatic logic [VEC_W-1:0] splat(input logic [LANE_W-1:0] val);
        logic [VEC_W-1:0] r;
        for (int i = 0; i < int'(N_LANES); i++) r[i*LANE_W +: LANE_W] = val;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Returns at the falling edge right after the accepting rising edge.
    task automatic send_batch(input logic [VEC_W-1:0] c, input logic [VEC_W-1:0] v,
                              input logic [LANE_W-1:0] th, input logic [LANE_W-1:0] r);
        @(negedge clk);
        cur_in = c; v_in = v; vth = th; rp = r; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        checks++; if (v_out !== '0) $display("FAIL reset_v_out got %h want 0", v_out); else passes++;
        checks++; if (spike_out !== '0) $display("FAIL reset_spike got %h want 0", spike_out); else passes++;
    endtask

    task automatic test_basic_fire();
        logic [VEC_W-1:0] c, ev;
        int n;
        do_reset();
        c = splat(32'd10); c[3*LANE_W +: LANE_W] = 32'd150;
        ev = splat(32'd10); ev[3*LANE_W +: LANE_W] = '0;
        send_batch(c, '0, 32'd100, 32'd2);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL basic_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); else passes++;
        wait_done(n);
        // 16 edges after accept = out_valid in cycle accept+17.
        checks++; if (n !== 16) $display("FAIL basic_latency got %0d want 16", n); else passes++;
        checks++; if (spike_out !== 16'h0008) $display("FAIL basic_spike got %h want 0008", spike_out); else passes++;
        checks++; if (v_out !== ev) $display("FAIL basic_v_out got %h want %h", v_out, ev); else passes++;
        release_result();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL basic_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else passes++;
    endtask

    // Runs right after test_basic_fire: lane 3 holds rc=2.
    task automatic test_refractory();
        logic [VEC_W-1:0] c, v, ev;
        int n;
        c = splat(32'd10); c[3*LANE_W +: LANE_W] = 32'd150;
        for (int b = 0; b < 3; b++) begin
            v = '0;
            if (b < 2) v[3*LANE_W +: LANE_W] = 32'd55;
            ev = splat(32'd10);
            ev[3*LANE_W +: LANE_W] = (b < 2) ? 32'd55 : 32'd0;
            send_batch(c, v, 32'd100, 32'd2);
            wait_done(n);
            checks++; if (out_valid !== 1'b1) $display("FAIL refr_timeout batch %0d got %b want 1", b, out_valid); else passes++;
            checks++; if (spike_out !== ((b < 2) ? 16'h0000 : 16'h0008))
                $display("FAIL refr_spike batch %0d got %h", b, spike_out); else passes++;
            checks++; if (v_out !== ev) $display("FAIL refr_v_out batch %0d got %h want %h", b, v_out, ev); else passes++;
            release_result();
        end
    endtask

    task automatic test_leak();
        logic [VEC_W-1:0] c, v, ev;
        int n;
        do_reset();
        v = splat(32'd160); v[5*LANE_W +: LANE_W] = -32'sd160;
        c = '0; c[7*LANE_W +: LANE_W] = 32'd850; c[8*LANE_W +: LANE_W] = 32'd849;
        ev = splat(32'd150); ev[5*LANE_W +: LANE_W] = -32'sd150;
        ev[7*LANE_W +: LANE_W] = '0; ev[8*LANE_W +: LANE_W] = 32'd999;
        send_batch(c, v, 32'd1000, 32'd0);
        wait_done(n);
        checks++; if (spike_out !== 16'h0080) $display("FAIL leak_spike got %h want 0080", spike_out); else passes++;
        checks++; if (v_out !== ev) $display("FAIL leak_v_out got %h want %h", v_out, ev); else passes++;
        release_result();
    endtask

    task automatic test_saturation();
        logic [VEC_W-1:0] ev;
        int n;
        do_reset();
        send_batch(splat(32'h7FFF_FFF0), splat(32'h7FFF_FFF0), 32'h7FFF_FFFF, 32'd0);
        wait_done(n);
        checks++; if (spike_out !== 16'hFFFF) $display("FAIL sat_pos_spike got %h want ffff", spike_out); else passes++;
        checks++; if (v_out !== '0) $display("FAIL sat_pos_v_out got %h want 0", v_out); else passes++;
        release_result();
`ifdef LIF_SATURATE_EN
        ev = splat(32'h8000_0000);
`else
        ev = splat(32'h0800_0000);
`endif
        send_batch(splat(32'h8000_0000), splat(32'h8000_0000), 32'h7FFF_FFFF, 32'd0);
        wait_done(n);
        checks++; if (spike_out !== 16'h0000) $display("FAIL sat_neg_spike got %h want 0000", spike_out); else passes++;
        checks++; if (v_out !== ev) $display("FAIL sat_neg_v_out got %h want %h", v_out, ev); else passes++;
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [VEC_W-1:0] c;
        int first, second, nspk;
        do_reset();
        c = '0; c[0 +: LANE_W] = 32'd200;
        cur_in = c; v_in = '0; vth = 32'd100; rp = 32'd0;
        out_ready = 1'b1; in_valid = 1'b1;
        first = -1; second = -1; nspk = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                if (first < 0) first = t; else if (second < 0) second = t;
            end
            if (out_valid === 1'b1 && nspk < 2) begin
                checks++; if (spike_out !== 16'h0001) $display("FAIL b2b_spike %0d got %h want 0001", nspk, spike_out); else passes++;
                nspk++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (second - first !== 18) $display("FAIL b2b_period got %0d want 18", second - first); else passes++;
        checks++; if (nspk !== 2) $display("FAIL b2b_results got %0d want 2", nspk); else passes++;
    endtask

    task automatic test_backpressure();
        logic [VEC_W-1:0] c, ev, v2, ev2;
        int n;
        do_reset();
        c = splat(32'd10); c[3*LANE_W +: LANE_W] = 32'd150;
        ev = splat(32'd10); ev[3*LANE_W +: LANE_W] = '0;
        send_batch(c, '0, 32'd100, 32'd2);
        wait_done(n);
        v2 = splat(32'd7);
        for (int k = 0; k < 10; k++) begin
            cur_in = splat(32'd500); v_in = v2; vth = 32'd100; rp = 32'd0; in_valid = 1'b1;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_hold %0d got out_valid=%b in_ready=%b want 1/0", k, out_valid, in_ready); else passes++;
            checks++; if (v_out !== ev || spike_out !== 16'h0008)
                $display("FAIL bp_stable %0d got spike %h v_out %h", k, spike_out, v_out); else passes++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || v_out !== ev)
            $display("FAIL bp_release got in_ready=%b out_valid=%b", in_ready, out_valid); else passes++;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL bp_accept got busy=%b want 1", busy); else passes++;
        wait_done(n);
        // Lane 3 still refractory: held at its new v_in, no spike.
        ev2 = '0; ev2[3*LANE_W +: LANE_W] = 32'd7;
        checks++; if (spike_out !== 16'hFFF7) $display("FAIL bp_next_spike got %h want fff7", spike_out); else passes++;
        checks++; if (v_out !== ev2) $display("FAIL bp_next_v_out got %h want %h", v_out, ev2); else passes++;
        release_result();
    endtask

    task automatic test_reset_mid();
        logic [VEC_W-1:0] c;
        int n, seen;
        do_reset();
        c = splat(32'd10); c[3*LANE_W +: LANE_W] = 32'd150;
        send_batch(c, '0, 32'd100, 32'd2);
        wait_done(n);
        release_result();
        send_batch(c, '0, 32'd100, 32'd2);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mid_reset_ctrl got out_valid=%b busy=%b in_ready=%b", out_valid, busy, in_ready); else passes++;
        checks++; if (v_out !== '0 || spike_out !== '0)
            $display("FAIL mid_reset_data got spike %h v_out %h want 0", spike_out, v_out); else passes++;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL mid_reset_aborted got %0d valid cycles want 0", seen); else passes++;
        send_batch(c, '0, 32'd100, 32'd2);
        wait_done(n);
        checks++; if (spike_out !== 16'h0008) $display("FAIL mid_reset_refire got %h want 0008", spike_out); else passes++;
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic_fire();
        test_refractory();
        test_leak();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
